// File: rtl/traffic_disp_pkg.sv
// traffic_disp_pkg
// Shared definitions for the traffic controller display path: digit and road
// index constants, the blank segment pattern, the slot FSM state type and the
// digit-to-road mapping used to pick a digit's blink_en bit.
package traffic_disp_pkg;

  // Digit slots in scan order; an[i] selects digit i.
  localparam logic [2:0] DIG_N_MSB = 3'd0;
  localparam logic [2:0] DIG_N_LSB = 3'd1;
  localparam logic [2:0] DIG_E_MSB = 3'd2;
  localparam logic [2:0] DIG_E_LSB = 3'd3;
  localparam logic [2:0] DIG_S_MSB = 3'd4;
  localparam logic [2:0] DIG_S_LSB = 3'd5;
  localparam logic [2:0] DIG_W_MSB = 3'd6;
  localparam logic [2:0] DIG_W_LSB = 3'd7;

  // Road indices are bit positions within blink_en.
  localparam logic [1:0] ROAD_N = 2'd3;
  localparam logic [1:0] ROAD_E = 2'd2;
  localparam logic [1:0] ROAD_S = 2'd1;
  localparam logic [1:0] ROAD_W = 2'd0;

  // Active-high segment pattern with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

  // Each road owns two consecutive digits (idx>>1), but blink_en lists the
  // roads N-first from the MSB, so the pair number is reversed.
  function automatic logic [1:0] digit_road(input logic [2:0] idx);
    return ~idx[2:1];
  endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// disp_slot_timer
// Slot timing for the display scanner: slot counter, BLANK/DRIVE FSM,
// current digit index and the end-of-scan pulse.
//   clk, reset  : clock, synchronous active-high reset
//   digit_idx   : digit currently being scanned (registered)
//   scan_done   : one-cycle pulse in the last cycle of slot 7 (registered)
//   capture     : high in the last BLANK cycle of a slot
//   drive_next  : the FSM will be in DRIVE during the next cycle
module disp_slot_timer
  import traffic_disp_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] digit_idx,
  output logic       scan_done,
  output logic       capture,
  output logic       drive_next
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] slot_cnt;
  logic          slot_last;
  slot_state_e   state;
  slot_state_e   state_next;

  assign slot_last = (slot_cnt == CW'(TICK_DIV - 1));

  // NOTE: every variable assigned here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      ST_BLANK: begin
        if (slot_cnt == CW'(BLANK_CYCLES - 1)) begin
          state_next = ST_DRIVE;
          capture    = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (slot_last) state_next = ST_BLANK;
      end
      default: state_next = ST_BLANK;
    endcase
  end

  assign drive_next = (state_next == ST_DRIVE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_BLANK;
      slot_cnt  <= '0;
      digit_idx <= DIG_N_MSB;
      scan_done <= 1'b0;
    end else begin
      state <= state_next;
      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end
      // Registered one cycle early so the pulse lands on slot_cnt==TICK_DIV-1.
      scan_done <= (digit_idx == DIG_W_LSB) && (slot_cnt == CW'(TICK_DIV - 2));
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Time-multiplexed driver for the eight traffic countdown digits. Scans the
// digits N_MSB..W_LSB on a shared segment bus with a blanking gap at the head
// of each slot, and can blink the digit pair of any road.
//   clk, reset         : clock, synchronous active-high reset
//   n/e/s/w_msb/lsb    : active-high segment patterns, a..g on [6:0]
//   blink_en           : per-road blink request, [3]=N [2]=E [1]=S [0]=W
//   seg                : shared segment bus, output polarity applied
//   an                 : digit enables, at most one active, polarity applied
//   digit_idx          : current slot index
//   scan_done          : one-cycle pulse at the end of slot 7
module seven_seg_scanner
  import traffic_disp_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter int unsigned BLINK_SCANS    = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] n_msb,
  input  logic [6:0] n_lsb,
  input  logic [6:0] e_msb,
  input  logic [6:0] e_lsb,
  input  logic [6:0] s_msb,
  input  logic [6:0] s_lsb,
  input  logic [6:0] w_msb,
  input  logic [6:0] w_lsb,
  input  logic [3:0] blink_en,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic [2:0] digit_idx,
  output logic       scan_done
);

  localparam int         SCW     = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0] AN_POL  = AN_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic           capture;
  logic           drive_next;
  logic [6:0]     pat_sel;
  logic [6:0]     pat_cap;
  logic [6:0]     pat_next;
  logic           blink_cap;
  logic           blink_next;
  logic           show_next;
  logic           blink_phase;
  logic [SCW-1:0] scan_cnt;

  disp_slot_timer #(
    .TICK_DIV     (TICK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .digit_idx  (digit_idx),
    .scan_done  (scan_done),
    .capture    (capture),
    .drive_next (drive_next)
  );

  always_comb begin
    pat_sel = SEG_OFF;
    case (digit_idx)
      DIG_N_MSB: pat_sel = n_msb;
      DIG_N_LSB: pat_sel = n_lsb;
      DIG_E_MSB: pat_sel = e_msb;
      DIG_E_LSB: pat_sel = e_lsb;
      DIG_S_MSB: pat_sel = s_msb;
      DIG_S_LSB: pat_sel = s_lsb;
      DIG_W_MSB: pat_sel = w_msb;
      DIG_W_LSB: pat_sel = w_lsb;
      default:   pat_sel = SEG_OFF;
    endcase
  end

  // The output registers are loaded from the values the capture registers are
  // about to hold, so a captured pattern reaches seg on the first DRIVE cycle.
  // blink_phase only moves at the slot 7 -> slot 0 boundary, when drive_next
  // is low, so it is stable for the whole of any slot.
  always_comb begin
    pat_next   = capture ? pat_sel : pat_cap;
    blink_next = capture ? blink_en[digit_road(digit_idx)] : blink_cap;
    show_next  = drive_next && !(blink_next && !blink_phase);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the capture registers are reset too, so a restarted scan never
      // carries a pattern or blink bit over from before the reset.
      pat_cap     <= SEG_OFF;
      blink_cap   <= 1'b0;
      scan_cnt    <= '0;
      blink_phase <= 1'b1;
      seg         <= SEG_OFF ^ SEG_POL;
      an          <= 8'h00 ^ AN_POL;
    end else begin
      pat_cap   <= pat_next;
      blink_cap <= blink_next;
      if (scan_done) begin
        if (scan_cnt == SCW'(BLINK_SCANS - 1)) begin
          scan_cnt    <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          scan_cnt <= scan_cnt + SCW'(1);
        end
      end
      // an and seg are loaded together, so an never goes active while seg
      // still holds the previous digit's pattern.
      seg <= (show_next ? pat_next : SEG_OFF) ^ SEG_POL;
      an  <= (show_next ? (8'b1 << digit_idx) : 8'h00) ^ AN_POL;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
// Directed bench for seven_seg_scanner with TICK_DIV=8, BLANK_CYCLES=2,
// BLINK_SCANS=2 and both outputs active-low. One scan is 64 cycles.
module tb_seven_seg_scanner;

  localparam int TICK   = 8;
  localparam int BLANK  = 2;

  logic       clk;
  logic       reset;
  logic [6:0] n_msb, n_lsb, e_msb, e_lsb, s_msb, s_lsb, w_msb, w_lsb;
  logic [3:0] blink_en;
  logic [6:0] seg;
  logic [7:0] an;
  logic [2:0] digit_idx;
  logic       scan_done;

  logic [6:0] pats [8];
  int checks = 0;
  int errors = 0;

  seven_seg_scanner #(
    .TICK_DIV       (TICK),
    .BLANK_CYCLES   (BLANK),
    .BLINK_SCANS    (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .n_msb     (n_msb),
    .n_lsb     (n_lsb),
    .e_msb     (e_msb),
    .e_lsb     (e_lsb),
    .s_msb     (s_msb),
    .s_lsb     (s_lsb),
    .w_msb     (w_msb),
    .w_lsb     (w_lsb),
    .blink_en  (blink_en),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_pats();
    n_msb = pats[0]; n_lsb = pats[1];
    e_msb = pats[2]; e_lsb = pats[3];
    s_msb = pats[4]; s_lsb = pats[5];
    w_msb = pats[6]; w_lsb = pats[7];
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " an"},        an,        32'hFF);
    check({tag, " seg"},       seg,       32'h7F);
    check({tag, " digit_idx"}, digit_idx, 32'h0);
    check({tag, " scan_done"}, scan_done, 32'h0);
  endtask

  // Called at the negedge of cycle k0 of slot d; checks cycles k0..k1-1 and
  // returns at the negedge of cycle k1.
  task automatic run_slot(input int d, input logic [6:0] pat, input bit vis,
                          input int k0, input int k1);
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    for (int k = k0; k < k1; k++) begin
      if (vis && k >= BLANK) begin
        exp_an  = ~(8'b1 << d);
        exp_seg = ~pat;
      end else begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
      end
      check($sformatf("an d%0d k%0d", d, k),   an,        {24'h0, exp_an});
      check($sformatf("seg d%0d k%0d", d, k),  seg,       {25'h0, exp_seg});
      check($sformatf("idx d%0d k%0d", d, k),  digit_idx, d);
      check($sformatf("done d%0d k%0d", d, k), scan_done, (d == 7 && k == TICK - 1) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  task automatic run_scan(input logic [7:0] vis);
    for (int d = 0; d < 8; d++) run_slot(d, pats[d], vis[d], 0, TICK);
  endtask

  initial begin
    int         dd;
    int         kk;
    int         ones;
    logic       ok;
    logic [6:0] cap;

    reset    = 1'b1;
    blink_en = 4'b0000;
    pats     = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h55};
    apply_pats();

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Scan 1: order 0..7, first active an two cycles after release.
    run_scan(8'hFF);

    // Scan 2: n_msb changes on the third DRIVE cycle of slot 0.
    pats[0] = 7'h3F;
    apply_pats();
    run_slot(0, 7'h3F, 1'b1, 0, 4);
    pats[0] = 7'h06;
    apply_pats();
    run_slot(0, 7'h3F, 1'b1, 4, TICK);
    for (int d = 1; d < 8; d++) run_slot(d, pats[d], 1'b1, 0, TICK);

    // Scan 3: blink phase is now hidden; E blinks, N shows the new pattern.
    blink_en = 4'b0100;
    run_slot(0, 7'h06,   1'b1, 0, TICK);
    run_slot(1, pats[1], 1'b1, 0, TICK);
    run_slot(2, pats[2], 1'b0, 0, TICK);
    run_slot(3, pats[3], 1'b0, 0, TICK);
    run_slot(4, pats[4], 1'b1, 0, TICK);
    run_slot(5, pats[5], 1'b1, 0, 4);

    // Reset in the middle of slot 5 DRIVE.
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;

    // Six scans with E blinking: visible, visible, hidden x2, visible x2.
    for (int s = 1; s <= 6; s++) run_scan((s == 3 || s == 4) ? 8'hF3 : 8'hFF);

    // Random inputs: at most one digit active, and an active digit always
    // shows the pattern present at its capture cycle.
    dd  = 0;
    kk  = 0;
    cap = 7'h00;
    for (int c = 0; c < 10000; c++) begin
      ones = $countones(~an);
      ok   = (ones <= 1) && (digit_idx == 3'(dd)) &&
             ((an == 8'hFF) ? (seg == 7'h7F)
                            : (kk >= BLANK && an == ~(8'b1 << dd) && seg == ~cap));
      check($sformatf("excl c%0d", c), {31'h0, ok}, 32'h1);
      for (int i = 0; i < 8; i++) pats[i] = 7'($urandom);
      apply_pats();
      blink_en = 4'($urandom_range(0, 15));
      if (kk == BLANK - 1) cap = pats[dd];
      kk++;
      if (kk == TICK) begin
        kk = 0;
        dd = (dd + 1) % 8;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the eight countdown digits of the traffic controller's display board. It sits directly downstream of the display/timer stage and consumes the eight 7-bit segment patterns it produces: north, east, south and west, each with an MSB and an LSB digit. It drives one shared segment bus and eight digit enables, adds inter-digit blanking to suppress ghosting, and can blink any road's pair of digits.

## Interface
- `TICK_DIV`, default 100000: clock cycles per digit slot. Must be at least 4.
- `BLANK_CYCLES`, default 1000: leading cycles of each slot with all digits off. Range is 1 to `TICK_DIV`-2.
- `BLINK_SCANS`, default 64: number of complete 8-digit scans per blink half-period. Must be at least 1.
- `SEG_ACTIVE_LOW`, default 1: when 1, segment outputs are inverted, so a lit segment is 0.
- `AN_ACTIVE_LOW`, default 1: when 1, digit enables are inverted, so the selected digit is 0.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: synchronous, active-high.
- `n_msb`, `n_lsb`, `e_msb`, `e_lsb`, `s_msb`, `s_lsb`, `w_msb`, `w_lsb` inputs, 7 bits each: segment patterns, active-high, bits a..g on [6:0].
- `blink_en` input, 4 bits: per-road blink request, mapped as [3]=N, [2]=E, [1]=S, [0]=W.
- `seg` output, 7 bits: shared segment bus, after polarity is applied.
- `an` output, 8 bits: digit enables, at most one active at a time, after polarity is applied.
- `digit_idx` output, 3 bits: index of the current slot.
- `scan_done` output, 1 bit: one-cycle pulse at the end of slot 7.

## Operation
- Digit order by index:
  - 0 = `n_msb`, 1 = `n_lsb`
  - 2 = `e_msb`, 3 = `e_lsb`
  - 4 = `s_msb`, 5 = `s_lsb`
  - 6 = `w_msb`, 7 = `w_lsb`
  - `an[i]` selects digit i.
- Slot counter `slot_cnt` counts 0 to `TICK_DIV`-1, then wraps to 0. On wrap, `digit_idx` increments, with 7 wrapping to 0.
- The FSM has two states, BLANK and DRIVE:
  - BLANK covers `slot_cnt` 0 to `BLANK_CYCLES`-1.
  - DRIVE covers `slot_cnt` from `BLANK_CYCLES` to `TICK_DIV`-1.
  - Transition BLANK→DRIVE occurs at `slot_cnt`==`BLANK_CYCLES`-1.
  - Transition DRIVE→BLANK occurs at slot wrap.
- Capture: on the last BLANK cycle, two values are registered and held constant for the whole DRIVE phase:
  - the selected digit's pattern;
  - `blink_en` for that digit's road.
  - Input changes during DRIVE do not affect the current slot (no tearing).
- BLANK phase: all `an` inactive and `seg` all-off.
- DRIVE phase: `an` selects `digit_idx` and `seg` shows the captured pattern.
- Blink:
  - `blink_phase` starts at 1 (visible).
  - A scan counter counts `scan_done` pulses. When it reaches `BLINK_SCANS`, `blink_phase` toggles and the counter clears.
  - When `blink_phase`==0 and the captured blink bit is 1, the whole slot behaves as BLANK (`an` inactive, `seg` off). Slot timing is unchanged.
- `scan_done` is asserted in the cycle where `slot_cnt`==`TICK_DIV`-1 and `digit_idx`==7.
- Polarity: inversion applies only at the output registers. Internal logic is active-high.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- Reset values, held in the cycle after `reset` is sampled high:
  - `slot_cnt` = 0, `digit_idx` = 0, state BLANK;
  - scan counter 0, `blink_phase` 1, captured pattern 0;
  - `an` all inactive: 8'hFF when `AN_ACTIVE_LOW`;
  - `seg` all off: 7'h7F when `SEG_ACTIVE_LOW`;
  - `scan_done` 0.
- Reset asserted mid-slot or mid-scan aborts immediately. The first post-reset slot is digit 0, starting with a full BLANK phase.
- Capture-to-display latency: a pattern present on the last BLANK cycle appears on `seg` on the first DRIVE cycle, exactly 1 clock later.
- `an` and `seg` change in the same cycle. `an` is never active while `seg` shows the previous digit's pattern.
- `blink_phase` toggles on the cycle after the `BLINK_SCANS`-th `scan_done`, so the boundary always falls on a slot-0 BLANK phase.
- A `blink_en` change takes effect at the next capture.
- Full period: one scan is 8×`TICK_DIV` cycles. One blink period is 2×`BLINK_SCANS` scans.

## Structure
- Shared package `traffic_disp_pkg`:
  - digit index constants `DIG_N_MSB` to `DIG_W_LSB`;
  - road index constants `ROAD_N`, `ROAD_E`, `ROAD_S`, `ROAD_W`;
  - `SEG_OFF` = 7'h00;
  - the digit-to-road mapping function (road = idx>>1, reversed to match `blink_en` order).
- Sub-module `disp_slot_timer`, parameterised by `TICK_DIV` and `BLANK_CYCLES`:
  - contains the slot counter, the BLANK/DRIVE FSM, `digit_idx` and `scan_done`;
  - the top level holds capture, blink and output polarity.

## Test plan
Bench parameters: `TICK_DIV`=8, `BLANK_CYCLES`=2, `BLINK_SCANS`=2, `SEG_ACTIVE_LOW`=1, `AN_ACTIVE_LOW`=1.

- **Reset:** assert `reset` for 3 cycles → `an`=8'hFF, `seg`=7'h7F, `digit_idx`=0, `scan_done`=0. First `an`=8'hFE appears exactly 2 cycles after `reset` deasserts.
- **Scan order:** drive distinct patterns 7'h01 to 7'h80>>1 onto digits 0..7 → each slot shows 2 cycles of 8'hFF, then 6 cycles of one-hot-low `an` with `seg`=~pattern, in order 0..7. `scan_done` pulses once every 64 cycles.
- **No tearing:** change `n_msb` from 7'h3F to 7'h06 on the 3rd DRIVE cycle of slot 0 → `seg` holds ~7'h3F to the end of the slot. The next scan's slot 0 shows ~7'h06.
- **Blink:** `blink_en`=4'b0100 (E) → slots 2 and 3 are fully blank during scans 3–4, visible in scans 1–2 and 5–6. Other roads are unaffected.
- **Mid-scan reset:** assert `reset` during slot 5 DRIVE → outputs go to reset values the next cycle, and the scan restarts at digit 0 with blink phase visible.
- **Exclusivity:** random inputs over 10,000 cycles → `an` is never more than one-hot-active, and `an` never changes without `seg` being updated in the same cycle.
